// File: rtl/fs_serial_sub.sv
// fs_serial_sub: bit-serial WIDTH-bit subtractor built on one full-subtractor cell.
// One operand bit is processed per clock, LSB first, and each bit's borrow feeds
// the next bit. This trades latency for area compared with a ripple subtractor.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request strobe, accepted only in IDLE
//   a, b   minuend / subtrahend, sampled when start is accepted
//   bin    initial borrow-in, sampled when start is accepted
//   busy   high in RUN and DONE
//   done   one-cycle pulse when d/br are newly updated
//   d      registered difference (a - b - bin) mod 2^WIDTH
//   br     registered final borrow-out
//
// state | meaning
// IDLE  | waiting for start; d/br hold the last result
// RUN   | one cell evaluation per edge, LSB first
// DONE  | one-cycle done pulse, then back to IDLE
module fs_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             br
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;

  logic             cell_d;
  logic             cell_br;
  logic [WIDTH-1:0] res_sh_d;

  // Full-subtractor cell on the current LSBs; the difference bit enters the
  // result register from the MSB side so the word is aligned after WIDTH shifts.
  always_comb begin
    cell_d  = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    cell_br = (~a_sh_q[0] & b_sh_q[0]) | (~a_sh_q[0] & borrow_q) | (b_sh_q[0] & borrow_q);
    res_sh_d = res_sh_q >> 1;
    res_sh_d[WIDTH-1] = cell_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_sh_d;
          borrow_q <= cell_br;
          if (cnt_q == LAST) begin
            // Counter is left at its terminal value so it never wraps when
            // WIDTH is a power of two.
            d_q     <= res_sh_d;
            br_q    <= cell_br;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign br   = br_q;

endmodule
